sbox_layer_ctrl: RTL and testbench

- Sequences one full nonlinear layer of the uBlock state through a single 2-share shared_sbox instance, one nibble per cycle.
- Captures both state shares on start and issues nibbles with fresh 4-bit guards from an external randomness source.
- Tracks the S-box pipeline latency with a valid/tag shift register and writes results back in place.
- Sits between the round controller and the shared_sbox datapath; the S-box instance itself lives outside this block.

---
 rtl/sbox_layer_ctrl_pkg.sv | 22 ++
 rtl/sbox_layer_ctrl_valid.sv | 50 +++++
 rtl/sbox_layer_ctrl.sv | 134 +++++++++++++
 tb/tb_sbox_layer_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sbox_layer_ctrl_pkg.sv
// Shared definitions for the uBlock nonlinear-layer sequencer: FSM encoding,
// default geometry and the unshared S-box reference table.
package sbox_layer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } layer_state_t;

    localparam int DEF_NIBBLES  = 32;
    localparam int DEF_SBOX_LAT = 2;

    // Nibble i holds S(i): {7,4,9,C,B,A,D,8,F,E,1,6,0,3,2,5}
    localparam logic [63:0] UBLOCK_SBOX_TABLE = 64'h5230_61EF_8DAB_C947;

    function automatic logic [3:0] ublock_sbox(input logic [3:0] x);
        return UBLOCK_SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sbox_layer_ctrl_valid.sv
// Fixed-latency {valid, tag} shift register that mirrors the external S-box
// pipeline so each result can be routed back to the nibble it came from.
module sbox_valid_pipe
    import sbox_layer_ctrl_pkg::*;
#(
    parameter int LAT   = DEF_SBOX_LAT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [TAG_W-1:0] push_tag,
    output logic             head_valid,
    output logic [TAG_W-1:0] head_tag
);

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        tag_reg   <= '0;
                    end else begin
                        valid_reg <= push_valid;
                        tag_reg   <= push_tag;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        tag_reg   <= '0;
                    end else begin
                        valid_reg <= g_stage[gi-1].valid_reg;
                        tag_reg   <= g_stage[gi-1].tag_reg;
                    end
                end
            end
        end
    endgenerate

    assign head_valid = g_stage[LAT-1].valid_reg;
    assign head_tag   = g_stage[LAT-1].tag_reg;

endmodule

// File: rtl/sbox_layer_ctrl.sv
// Streams both shares of the state through one external shared S-box, a nibble
// per guarded issue, and writes the delayed results back into the same nibble.
module sbox_layer_ctrl
    import sbox_layer_ctrl_pkg::*;
#(
    parameter int NIBBLES  = DEF_NIBBLES,
    parameter int SBOX_LAT = DEF_SBOX_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   state0_in,
    input  logic [4*NIBBLES-1:0]   state1_in,
    input  logic [3:0]             rnd_in,
    input  logic                   rnd_valid,
    output logic                   rnd_req,
    output logic [3:0]             sb_in0,
    output logic [3:0]             sb_in1,
    output logic [3:0]             sb_guards,
    input  logic [3:0]             sb_out0,
    input  logic [3:0]             sb_out1,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   state0_out,
    output logic [4*NIBBLES-1:0]   state1_out
);

    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    layer_state_t     state_reg, state_next;
    logic [3:0]       sh0_reg [NIBBLES];
    logic [3:0]       sh1_reg [NIBBLES];
    logic [CNT_W-1:0] issue_cnt_reg;
    logic [CNT_W-1:0] retire_cnt_reg;
    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] head_tag;
    logic             head_valid;
    logic             issue;

    // Only meaningful in RUN, where issue_cnt is always below NIBBLES.
    assign issue_idx = issue_cnt_reg[IDX_W-1:0];

    sbox_valid_pipe #(
        .LAT   (SBOX_LAT),
        .TAG_W (IDX_W)
    ) u_valid_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue),
        .push_tag   (issue_idx),
        .head_valid (head_valid),
        .head_tag   (head_tag)
    );

    always_comb begin
        state_next = state_reg;
        rnd_req    = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sb_in0     = 4'h0;
        sb_in1     = 4'h0;
        sb_guards  = 4'h0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy    = 1'b1;
                rnd_req = 1'b1;
                // Shares are only put on the S-box bus together with fresh guards.
                if (rnd_valid) begin
                    issue     = 1'b1;
                    sb_in0    = sh0_reg[issue_idx];
                    sb_in1    = sh1_reg[issue_idx];
                    sb_guards = rnd_in;
                    if (issue_cnt_reg == CNT_W'(NIBBLES - 1)) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (head_valid && retire_cnt_reg == CNT_W'(NIBBLES - 1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            issue_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            for (int i = 0; i < NIBBLES; i++) begin
                sh0_reg[i] <= 4'h0;
                sh1_reg[i] <= 4'h0;
            end
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                issue_cnt_reg  <= '0;
                retire_cnt_reg <= '0;
                for (int i = 0; i < NIBBLES; i++) begin
                    sh0_reg[i] <= state0_in[4*i +: 4];
                    sh1_reg[i] <= state1_in[4*i +: 4];
                end
            end else begin
                if (issue) issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                if (head_valid) begin
                    retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (head_tag == IDX_W'(i)) begin
                            sh0_reg[i] <= sb_out0;
                            sh1_reg[i] <= sb_out1;
                        end
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_pack
            assign state0_out[4*gi +: 4] = sh0_reg[gi];
            assign state1_out[4*gi +: 4] = sh1_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Directed bench for sbox_layer_ctrl with a 2-cycle behavioural shared S-box
// that re-masks each result with the issued guards.
module tb_sbox_layer_ctrl;
    import sbox_layer_ctrl_pkg::*;

    localparam logic [127:0] PAT      = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT_RES  = 128'h749CBAD8FE160325749CBAD8FE160325;
    localparam logic [127:0] PAT2     = 128'hFEDCBA98765432100000000000000000;
    localparam logic [127:0] PAT2_RES = 128'h523061EF8DABC9477777777777777777;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] state0_in = '0;
    logic [127:0] state1_in = '0;
    logic [3:0]   rnd_in = '0;
    logic         rnd_valid = 1'b0;
    logic         rnd_req;
    logic [3:0]   sb_in0, sb_in1, sb_guards;
    logic [3:0]   sb_out0 = '0;
    logic [3:0]   sb_out1 = '0;
    logic         busy, done;
    logic [127:0] state0_out, state1_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sbox_layer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state0_in  (state0_in),
        .state1_in  (state1_in),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .rnd_req    (rnd_req),
        .sb_in0     (sb_in0),
        .sb_in1     (sb_in1),
        .sb_guards  (sb_guards),
        .sb_out0    (sb_out0),
        .sb_out1    (sb_out1),
        .busy       (busy),
        .done       (done),
        .state0_out (state0_out),
        .state1_out (state1_out)
    );

    // Behavioural shared S-box: two register stages, output re-masked by guards
    logic [3:0] m_x = '0;
    logic [3:0] m_g = '0;
    always @(posedge clk) begin
        m_x     <= sb_in0 ^ sb_in1;
        m_g     <= sb_guards;
        sb_out0 <= ublock_sbox(m_x) ^ m_g;
        sb_out1 <= m_g;
    end

    // mode 0: rnd_valid always 1; 1: valid on odd cycles; 2: stalled for 100 cycles;
    // 3: always valid with a second start pulse at cycle 5
    task automatic drive_layer(input logic [127:0] s0, input logic [127:0] s1, input int mode,
                               output int done_cyc, output int n_done, output int n_issued,
                               output int bad_issue, output int bad_bubble, output int bad_stall);
        logic rv;
        done_cyc = -1; n_done = 0; n_issued = 0;
        bad_issue = 0; bad_bubble = 0; bad_stall = 0;
        @(posedge clk); #1;
        state0_in = s0; state1_in = s1; start = 1'b1; rnd_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; state0_in = ~s0; state1_in = s1 ^ 128'h1;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            case (mode)
                1:       rv = cyc[0];
                2:       rv = (cyc > 100);
                default: rv = 1'b1;
            endcase
            rnd_valid = rv;
            rnd_in    = 4'($urandom());
            start     = (mode == 3 && cyc == 5);
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (rv && rnd_req === 1'b1) begin
                if (n_issued < 32) begin
                    if (sb_in0 !== s0[4*n_issued +: 4] || sb_in1 !== s1[4*n_issued +: 4] ||
                        sb_guards !== rnd_in)
                        bad_issue++;
                end else begin
                    bad_issue++;
                end
                n_issued++;
            end else if (sb_in0 !== 4'h0 || sb_in1 !== 4'h0 || sb_guards !== 4'h0) begin
                bad_bubble++;
            end
            if (mode == 2 && cyc <= 100 &&
                (busy !== 1'b1 || done !== 1'b0 || rnd_req !== 1'b1))
                bad_stall++;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        rnd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rnd_req !== 1'b0) begin failures++; $display("FAIL reset_rnd_req: got %b expected 0", rnd_req); end
        checks++; if ({sb_in0, sb_in1, sb_guards} !== 12'h000) begin
            failures++; $display("FAIL reset_sb_bus: got %h expected 000", {sb_in0, sb_in1, sb_guards}); end
        checks++; if ({state0_out, state1_out} !== 256'h0) begin
            failures++; $display("FAIL reset_state_out: got %h/%h expected 0", state0_out, state1_out); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored: got busy=%b expected 0", busy); end
        $display("reset: busy=%b done=%b rnd_req=%b", busy, done, rnd_req);
    endtask

    task automatic run_and_check(input string name, input logic [127:0] s0, input logic [127:0] s1,
                                 input int mode, input logic [127:0] exp_res, input int exp_done);
        int dc, nd, ni, bi, bb, bs;
        drive_layer(s0, s1, mode, dc, nd, ni, bi, bb, bs);
        $display("layer %s: done_cyc=%0d dones=%0d issued=%0d result=%h", name, dc, nd, ni,
                 state0_out ^ state1_out);
        checks++; if (dc !== exp_done) begin failures++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, exp_done); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL %s_done_pulses: got %0d expected 1", name, nd); end
        checks++; if (ni !== 32) begin failures++; $display("FAIL %s_issued: got %0d expected 32", name, ni); end
        checks++; if (bi !== 0) begin failures++; $display("FAIL %s_issue_bus: got %0d bad issues expected 0", name, bi); end
        checks++; if (bb !== 0) begin failures++; $display("FAIL %s_bubble_bus: got %0d exposed bubbles expected 0", name, bb); end
        checks++; if ((state0_out ^ state1_out) !== exp_res) begin
            failures++; $display("FAIL %s_result: got %h expected %h", name, state0_out ^ state1_out, exp_res); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle_after: got busy=%b expected 0", name, busy); end
        if (mode == 2) begin
            checks++; if (bs !== 0) begin failures++; $display("FAIL %s_stall: got %0d bad stall cycles expected 0", name, bs); end
        end
    endtask

    task automatic test_zero;
        run_and_check("zero", 128'h0, 128'h0, 0, {32{4'h7}}, 35);
    endtask

    task automatic test_pattern;
        logic [127:0] m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_and_check("pattern", m, m ^ PAT, 0, PAT_RES, 35);
    endtask

    task automatic test_bubbles;
        logic [127:0] m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_and_check("bubbles", m ^ PAT2, m, 1, PAT2_RES, 66);
    endtask

    task automatic test_stall;
        logic [127:0] m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_and_check("stall", m, m ^ PAT, 2, PAT_RES, 135);
    endtask

    task automatic test_start_ignored;
        logic [127:0] m;
        m = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_and_check("restart", m, m ^ PAT2, 3, PAT2_RES, 35);
    endtask

    task automatic test_reset_mid_run;
        @(posedge clk); #1;
        state0_in = PAT; state1_in = 128'h0; start = 1'b1; rnd_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            rnd_valid = 1'b1;
            rnd_in = 4'($urandom());
            if (cyc == 9) begin
                @(negedge clk);
                checks++; if (busy !== 1'b1 || state0_out === 128'h0) begin
                    failures++; $display("FAIL midrst_pre: got busy=%b state0_out=%h expected busy=1 nonzero", busy, state0_out); end
            end
            if (cyc == 10) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0; rnd_valid = 1'b0;
        @(negedge clk);
        $display("midrst: busy=%b rnd_req=%b state0_out=%h state1_out=%h", busy, rnd_req, state0_out, state1_out);
        checks++; if (busy !== 1'b0 || rnd_req !== 1'b0) begin
            failures++; $display("FAIL midrst_busy: got busy=%b rnd_req=%b expected 0/0", busy, rnd_req); end
        checks++; if ({state0_out, state1_out} !== 256'h0) begin
            failures++; $display("FAIL midrst_state: got %h/%h expected 0", state0_out, state1_out); end
        run_and_check("after_rst", {32{4'hF}}, 128'h0, 0, {32{4'h5}}, 35);
    endtask

    initial begin
        test_reset;
        test_zero;
        test_pattern;
        test_bubbles;
        test_reset_mid_run;
        test_start_ignored;
        test_stall;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
